// File: rtl/div_unit_pkg.sv
// Shared widths, state encodings and small helpers for the multi-cycle divider.
// The zero-divisor and overflow paths stage their fixed result in DIV_BY_ZERO.
package div_unit_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
    localparam logic [REG_BUS-1:0] ALL_ONES  = '1;
    localparam logic [REG_BUS-1:0] INT_MIN   = {1'b1, {(REG_BUS-1){1'b0}}};

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    function automatic logic [REG_BUS-1:0] negate_word(input logic [REG_BUS-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [REG_BUS-1:0] abs_word(input logic [REG_BUS-1:0] v,
                                                    input logic            is_signed);
        return (is_signed && v[REG_BUS-1]) ? negate_word(v) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring 32-bit divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle; result and ready are fully registered.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e                state_reg, state_next;
    logic [5:0]                cnt_reg, cnt_next;
    logic [REG_BUS-1:0]        partial_reg, partial_next;
    logic [REG_BUS-1:0]        dividend_reg, dividend_next;
    logic [REG_BUS-1:0]        divisor_reg, divisor_next;
    logic                      neg_quot_reg, neg_quot_next;
    logic                      neg_rem_reg, neg_rem_next;
    logic [DOUBLE_REG_BUS-1:0] result_reg, result_next;
    logic                      ready_reg, ready_next;

    // The partial remainder always fits in 32 bits; the 33rd bit exists only
    // in the shifted trial value so a divisor >= 0x80000000 cannot overflow.
    logic [REG_BUS:0]          trial_shift;
    logic [REG_BUS:0]          trial_diff;
    logic [REG_BUS-1:0]        quot_fixed;
    logic [REG_BUS-1:0]        rem_fixed;

    always_comb begin
        trial_shift = {partial_reg, dividend_reg[REG_BUS-1]};
        trial_diff  = trial_shift - {1'b0, divisor_reg};
        quot_fixed  = neg_quot_reg ? negate_word(dividend_reg) : dividend_reg;
        rem_fixed   = neg_rem_reg  ? negate_word(partial_reg)  : partial_reg;
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        partial_next  = partial_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        neg_quot_next = neg_quot_reg;
        neg_rem_next  = neg_rem_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        if (annul_i) begin
            state_next  = DIV_FREE;
            ready_next  = 1'b0;
            result_next = '0;
        end else begin
            unique case (state_reg)
                DIV_FREE: begin
                    if (start_i) begin
                        cnt_next      = '0;
                        neg_quot_next = 1'b0;
                        neg_rem_next  = 1'b0;
                        if (opdata2_i == ZERO_WORD) begin
                            dividend_next = ALL_ONES;
                            partial_next  = opdata1_i;
                            state_next    = DIV_BY_ZERO;
                        end else if (signed_div_i && opdata1_i == INT_MIN
                                     && opdata2_i == ALL_ONES) begin
                            dividend_next = INT_MIN;
                            partial_next  = ZERO_WORD;
                            state_next    = DIV_BY_ZERO;
                        end else begin
                            dividend_next = abs_word(opdata1_i, signed_div_i);
                            divisor_next  = abs_word(opdata2_i, signed_div_i);
                            neg_quot_next = signed_div_i
                                            && (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
                            neg_rem_next  = signed_div_i && opdata1_i[REG_BUS-1];
                            partial_next  = ZERO_WORD;
                            state_next    = DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (!start_i) begin
                        state_next = DIV_FREE;
                    end else begin
                        result_next = {rem_fixed, quot_fixed};
                        ready_next  = 1'b1;
                        state_next  = DIV_END;
                    end
                end
                DIV_ON: begin
                    if (!start_i) begin
                        state_next = DIV_FREE;
                    end else if (cnt_reg == 6'd32) begin
                        result_next = {rem_fixed, quot_fixed};
                        ready_next  = 1'b1;
                        state_next  = DIV_END;
                    end else begin
                        // Quotient bits shift in behind the consumed dividend bits.
                        partial_next  = trial_diff[REG_BUS] ? trial_shift[REG_BUS-1:0]
                                                            : trial_diff[REG_BUS-1:0];
                        dividend_next = {dividend_reg[REG_BUS-2:0], ~trial_diff[REG_BUS]};
                        cnt_next      = cnt_reg + 6'd1;
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        state_next  = DIV_FREE;
                        ready_next  = 1'b0;
                        result_next = '0;
                    end
                end
                default: state_next = DIV_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= DIV_FREE;
            cnt_reg      <= '0;
            partial_reg  <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            partial_reg  <= partial_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            neg_quot_reg <= neg_quot_next;
            neg_rem_reg  <= neg_rem_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against a plain-arithmetic RISC-V division model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int tests_run = 0;
    int tests_failed = 0;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V division rules in plain integer arithmetic.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        if (s) begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic int ref_latency(input bit s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic wait_ready(output int lat);
        lat = 0;
        while (!ready_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        exp = ref_div(s, a, b);
        @(negedge clk);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk); #1;
        signed_div_i = 1'($urandom);
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        check({tag, "_not_ready_e0"}, 64'(ready_o), 64'd0);
        wait_ready(lat);
        check({tag, "_latency"}, 64'(lat), 64'(ref_latency(s, a, b)));
        check({tag, "_result"}, result_o, exp);
        @(posedge clk); #1;
        check({tag, "_hold"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop"}, {63'(result_o), ready_o}, 64'd0);
        $display("[TB] %s s=%0d %h / %h -> q=%h r=%h lat=%0d", tag, s, a, b,
                 exp[31:0], exp[63:32], lat);
    endtask

    initial begin
        int          bad;
        int          lat;
        bit          s;
        logic [31:0] a;
        logic [31:0] b;

        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        check("reset_outputs", {63'(result_o), ready_o}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op("udiv_100_7", 1'b0, 32'd100, 32'd7);
        run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        run_op("udiv_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("udiv_by0", 1'b0, 32'd5, 32'd0);
        run_op("sdiv_by0", 1'b1, 32'd5, 32'd0);
        run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("udiv_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_op("sdiv_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9);

        // Annul in BUSY cycle 10: ready must never rise.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) bad++;
        end
        check("annul_quiet", 64'(bad), 64'd0);
        $display("[TB] annul in busy cycle 10");
        run_op("udiv_9_3", 1'b0, 32'd9, 32'd3);

        // Reset mid-BUSY.
        @(negedge clk);
        opdata1_i = 32'd12345;
        opdata2_i = 32'd17;
        start_i = 1'b1;
        repeat (16) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_busy", {63'(result_o), ready_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        $display("[TB] reset mid-busy");

        // Reset while result presented.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd77;
        opdata2_i = 32'd10;
        start_i = 1'b1;
        @(posedge clk); #1;
        wait_ready(lat);
        check("rst_done_pre", result_o, ref_div(1'b0, 32'd77, 32'd10));
        #2 rst = 1'b0;
        #1;
        check("rst_done", {63'(result_o), ready_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b1;
        $display("[TB] reset in done");

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = {1'b1, 31'($urandom)};
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op($sformatf("rand%0d", i), s, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
